// File: rtl/bsearch_pkg.sv
// Shared types and constants for the binary-search controller.
package bsearch_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    localparam int BS_WIDTH = 4;

    // Decode patterns for {A_grt_B, A_ls_B, A_eq_B}
    localparam logic [2:0] GRT = 3'b100;
    localparam logic [2:0] LS  = 3'b010;
    localparam logic [2:0] EQ  = 3'b001;

endpackage

// File: rtl/binary_search_ctrl.sv
// Binary-search controller driving a magnitude comparator's A operand.
// Optional BSEARCH_STEP_COUNT_EN adds a 'steps' output counting SEARCH cycles.
module binary_search_ctrl
    import bsearch_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             A_grt_B,
    input  logic             A_ls_B,
    input  logic             A_eq_B,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
`ifdef BSEARCH_STEP_COUNT_EN
    output logic [$clog2(WIDTH+2)-1:0] steps,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int LW = WIDTH + 1;
    localparam logic [LW-1:0]    MAX_V = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] FIRST = {1'b0, {(WIDTH-1){1'b1}}};

    state_e           state_q;
    logic [LW-1:0]    lo_q, hi_q, lo_d, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d, result_q;
    logic             busy_q, done_q, found_q, err_q;
    logic [2:0]       flags;
    logic             exhausted;
    logic [LW:0]      midSum;
`ifdef BSEARCH_STEP_COUNT_EN
    logic [$clog2(WIDTH+2)-1:0] steps_q;
`endif

    // The range empties exactly when the guess already sits on the bound being
    // moved; detecting it that way avoids relying on the wrapped value of 0-1.
    always_comb begin
        flags     = {A_grt_B, A_ls_B, A_eq_B};
        lo_d      = lo_q;
        hi_d      = hi_q;
        exhausted = 1'b0;
        if (flags == GRT) begin
            hi_d      = {1'b0, guess_q} - LW'(1);
            exhausted = ({1'b0, guess_q} <= lo_q);
        end else if (flags == LS) begin
            lo_d      = {1'b0, guess_q} + LW'(1);
            exhausted = ({1'b0, guess_q} >= hi_q);
        end
        midSum  = {1'b0, lo_d} + {1'b0, hi_d};
        guess_d = midSum[WIDTH:1];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= MAX_V;
            guess_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef BSEARCH_STEP_COUNT_EN
            steps_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= SEARCH;
                        lo_q    <= '0;
                        hi_q    <= MAX_V;
                        guess_q <= FIRST;
                        busy_q  <= 1'b1;
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
`ifdef BSEARCH_STEP_COUNT_EN
                        steps_q <= '0;
`endif
                    end
                end
                SEARCH: begin
`ifdef BSEARCH_STEP_COUNT_EN
                    steps_q <= steps_q + 1'b1;
`endif
                    if (flags == EQ) begin
                        result_q <= guess_q;
                        found_q  <= 1'b1;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if ((flags == GRT) || (flags == LS)) begin
                        lo_q <= lo_d;
                        hi_q <= hi_d;
                        if (exhausted) begin
                            err_q   <= 1'b1;
                            found_q <= 1'b0;
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            guess_q <= guess_d;
                        end
                    end else begin
                        err_q   <= 1'b1;
                        found_q <= 1'b0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign guess  = guess_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;
`ifdef BSEARCH_STEP_COUNT_EN
    assign steps  = steps_q;
`endif

endmodule
